// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: opcodes,
// controller states and flag bit positions.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_COUT = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin by default, fixed port-0 priority
// when ALU_SHARE_FIXED_PRIO_EN is defined.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr
);

`ifdef ALU_SHARE_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk, reset_n, accept};
  assign ptr = 1'b0;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      valid[0]:               grant = 2'b01;
      (valid == 2'b10):       grant = 2'b10;
      default:                grant = 2'b00;
    endcase
  end

`else

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = ptr_q ? 2'b10 : 2'b01;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

  // winner loses priority for the next contested round
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ~grant[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters.
// Build option: ALU_SHARE_FIXED_PRIO_EN (fixed port-0 priority).
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [2:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [2:0]       rsp1_flags,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             grant_id
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   gid_q, gid_d;
  logic                   busy_q, busy_d;
  logic [2:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [1:0]             rv_q, rv_d;
  logic [1:0][WIDTH-1:0]  rd_q, rd_d;
  logic [1:0][2:0]        rf_q, rf_d;

  logic [1:0] grant;
  logic       arb_ptr;
  logic       idle;
  logic       accept;
  logic [2:0] flags;
  logic [1:0] rsp_ready;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle && (req0_valid || req1_valid);
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid}),
    .accept  (accept),
    .grant   (grant),
    .ptr     (arb_ptr)
  );

  logic unused_ptr;
  assign unused_ptr = arb_ptr;

  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];

  always_comb begin
    flags            = 3'b000;
    flags[FLAG_COUT] = alu_cout;
    flags[FLAG_ZERO] = alu_zero;
    flags[FLAG_OVF]  = alu_overflow;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rf_d    = rf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gid_d   = grant[1];
          op_d    = grant[1] ? req1_op : req0_op;
          a_d     = grant[1] ? req1_a  : req0_a;
          b_d     = grant[1] ? req1_b  : req0_b;
          cnt_d   = 4'(ALU_LATENCY - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          rd_d[gid_q] = alu_out;
          rf_d[gid_q] = flags;
          rv_d[gid_q] = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[gid_q]) begin
          rv_d    = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        rv_d    = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gid_q   <= 1'b0;
      busy_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= '0;
      rd_q    <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rf_q    <= rf_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = busy_q;
  assign grant_id   = gid_q;
  assign rsp0_valid = rv_q[0];
  assign rsp1_valid = rv_q[1];
  assign rsp0_data  = rd_q[0];
  assign rsp1_data  = rd_q[1];
  assign rsp0_flags = rf_q[0];
  assign rsp1_flags = rf_q[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl (latency 1 and latency 3 instances)
// with a behavioural ALU attached to each instance.
module tb_alu_share_ctrl;

  localparam int W = 32;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // latency-1 instance
  logic         r0v, r1v, r0rdy, r1rdy;
  logic [2:0]   r0op, r1op;
  logic [W-1:0] r0a, r0b, r1a, r1b;
  logic         s0v, s1v, s0r, s1r;
  logic [W-1:0] s0d, s1d;
  logic [2:0]   s0f, s1f;
  logic [2:0]   aop;
  logic [W-1:0] aa, ab, aout;
  logic         acout, azero, aovf, busy, gid;

  // latency-3 instance
  logic         c0v, c1v, c0rdy, c1rdy;
  logic [2:0]   c0op, c1op;
  logic [W-1:0] c0a, c0b, c1a, c1b;
  logic         d0v, d1v, d0r, d1r;
  logic [W-1:0] d0d, d1d;
  logic [2:0]   d0f, d1f;
  logic [2:0]   cop;
  logic [W-1:0] ca, cb, cout_v;
  logic         ccout, czero, covf, cbusy, cgid;

  function automatic logic [W+2:0] alu_f(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b010: r = a ^ b;
      3'b011: r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      3'b100: r = a & b;
      3'b101: r = ~(a & b);
      3'b110: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, (r == '0), v, r};
  endfunction

  always_comb {acout, azero, aovf, aout} = alu_f(aop, aa, ab);
  always_comb {ccout, czero, covf, cout_v} = alu_f(cop, ca, cb);

  alu_share_ctrl #(.WIDTH(W), .ALU_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_op(r0op),
    .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_op(r1op),
    .req1_a(r1a), .req1_b(r1b),
    .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_data(s0d), .rsp0_flags(s0f),
    .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_data(s1d), .rsp1_flags(s1f),
    .alu_op(aop), .alu_a(aa), .alu_b(ab), .alu_out(aout),
    .alu_cout(acout), .alu_zero(azero), .alu_overflow(aovf),
    .busy(busy), .grant_id(gid)
  );

  alu_share_ctrl #(.WIDTH(W), .ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(c0v), .req0_ready(c0rdy), .req0_op(c0op),
    .req0_a(c0a), .req0_b(c0b),
    .req1_valid(c1v), .req1_ready(c1rdy), .req1_op(c1op),
    .req1_a(c1a), .req1_b(c1b),
    .rsp0_valid(d0v), .rsp0_ready(d0r), .rsp0_data(d0d), .rsp0_flags(d0f),
    .rsp1_valid(d1v), .rsp1_ready(d1r), .rsp1_data(d1d), .rsp1_flags(d1f),
    .alu_op(cop), .alu_a(ca), .alu_b(cb), .alu_out(cout_v),
    .alu_cout(ccout), .alu_zero(czero), .alu_overflow(covf),
    .busy(cbusy), .grant_id(cgid)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    r0v = 0; r1v = 0; r0op = 0; r1op = 0;
    r0a = 0; r0b = 0; r1a = 0; r1b = 0; s0r = 0; s1r = 0;
    c0v = 0; c1v = 0; c0op = 0; c1op = 0;
    c0a = 0; c0b = 0; c1a = 0; c1b = 0; d0r = 0; d1r = 0;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({busy, gid, s0v, s1v} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, gid, s0v, s1v});
    end
    checks++;
    if ({aop, aa, ab} !== '0) begin
      errs++; $display("FAIL reset_alu got=%h exp=0", {aop, aa, ab});
    end
    checks++;
    if ({s0d, s1d, s0f, s1f} !== '0) begin
      errs++; $display("FAIL reset_rsp got=%h exp=0", {s0d, s1d, s0f, s1f});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_xor_p0();
    r0v = 1; r0op = 3'b010; r0a = 32'hF0F0F0F0; r0b = 32'h0F0F0F0F;
    #1;
    checks++;
    if ({r1rdy, r0rdy} !== 2'b01) begin
      errs++; $display("FAIL xor_ready got=%b exp=01", {r1rdy, r0rdy});
    end
    @(posedge clk);
    @(negedge clk);
    r0v = 0;
    checks++;
    if ({busy, gid, s0v, aop, aa} !== {1'b1, 1'b0, 1'b0, 3'b010, 32'hF0F0F0F0}) begin
      errs++; $display("FAIL xor_exec got=%h", {busy, gid, s0v, aop, aa});
    end
    @(negedge clk);
    checks++;
    if ({s0v, s1v, s0d, s0f} !== {2'b10, 32'hFFFFFFFF, 3'b000}) begin
      errs++; $display("FAIL xor_rsp got=%h exp=%h", {s0v, s1v, s0d, s0f},
                       {2'b10, 32'hFFFFFFFF, 3'b000});
    end
    s0r = 1;
    @(negedge clk);
    s0r = 0;
    checks++;
    if ({busy, s0v} !== 2'b00) begin
      errs++; $display("FAIL xor_idle got=%b exp=00", {busy, s0v});
    end
  endtask

  task automatic test_both();
    int eid;
    do_reset();
    s0r = 1; s1r = 1;
    r0v = 1; r0op = 3'b000; r0a = 32'hFFFFFFFF; r0b = 32'h1;
    r1v = 1; r1op = 3'b010; r1a = 32'h12345678; r1b = 32'h12345678;
    for (int r = 0; r < 3; r++) begin
      eid = FIXED ? 0 : (r % 2);
      #1;
      checks++;
      if ({r1rdy, r0rdy} !== (eid ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL both_ready r=%0d got=%b exp_id=%0d", r, {r1rdy, r0rdy}, eid);
      end
      @(negedge clk);
      checks++;
      if ({busy, gid} !== {1'b1, eid[0]}) begin
        errs++; $display("FAIL both_gid r=%0d got=%b exp=1%0d", r, {busy, gid}, eid);
      end
      @(negedge clk);
      checks++;
      if (eid == 0) begin
        if ({s1v, s0v, s0d, s0f} !== {2'b01, 32'h0, 3'b110}) begin
          errs++; $display("FAIL both_rsp0 r=%0d got=%h", r, {s1v, s0v, s0d, s0f});
        end
      end else begin
        if ({s1v, s0v, s1d, s1f} !== {2'b10, 32'h0, 3'b010}) begin
          errs++; $display("FAIL both_rsp1 r=%0d got=%h", r, {s1v, s0v, s1d, s1f});
        end
      end
      @(negedge clk);
    end
    r0v = 0; r1v = 0; s0r = 0; s1r = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    r0v = 1; r0op = 3'b010; r0a = 32'hF0F0F0F0; r0b = 32'h0F0F0F0F;
    s0r = 0; s1r = 1;
    @(negedge clk);
    r1v = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({s0v, s1v, s0d, r0rdy, r1rdy, busy} !==
          {2'b10, 32'hFFFFFFFF, 3'b001}) begin
        errs++; $display("FAIL bp_hold i=%0d got=%h", i,
                         {s0v, s1v, s0d, r0rdy, r1rdy, busy});
      end
      @(negedge clk);
    end
    r0v = 0; r1v = 0; s0r = 1; s1r = 0;
    @(negedge clk);
    s0r = 0;
    checks++;
    if ({busy, s0v, s0d} !== {2'b00, 32'hFFFFFFFF}) begin
      errs++; $display("FAIL bp_release got=%h", {busy, s0v, s0d});
    end
  endtask

  task automatic test_latency3();
    c0v = 1; c0op = 3'b111; c0a = 32'h00FF0000; c0b = 32'h000000FF;
    #1;
    checks++;
    if (c0rdy !== 1'b1) begin
      errs++; $display("FAIL lat3_ready got=%b exp=1", c0rdy);
    end
    @(posedge clk);
    @(negedge clk);
    c0v = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cbusy, d0v, ca, cb} !== {2'b10, 32'h00FF0000, 32'h000000FF}) begin
        errs++; $display("FAIL lat3_exec i=%0d got=%h", i, {cbusy, d0v, ca, cb});
      end
      @(negedge clk);
    end
    checks++;
    if ({d0v, d0d, d0f} !== {1'b1, 32'h00FF00FF, 3'b000}) begin
      errs++; $display("FAIL lat3_rsp got=%h exp=%h", {d0v, d0d, d0f},
                       {1'b1, 32'h00FF00FF, 3'b000});
    end
    d0r = 1;
    @(negedge clk);
    d0r = 0;
    checks++;
    if ({cbusy, d0v} !== 2'b00) begin
      errs++; $display("FAIL lat3_idle got=%b exp=00", {cbusy, d0v});
    end
  endtask

  task automatic test_reset_mid();
    r0v = 1; r0op = 3'b111; r0a = 32'h1; r0b = 32'h2;
    @(posedge clk);
    @(negedge clk);
    r0v = 0;
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL rmid_exec got=%b exp=1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, gid, s0v, s1v, aop, aa, ab, s0d, s0f} !== '0) begin
      errs++; $display("FAIL rmid_async got=%h exp=0",
                       {busy, gid, s0v, s1v, aop, aa, ab, s0d, s0f});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, s0v, s1v} !== 3'b000) begin
        errs++; $display("FAIL rmid_drop i=%0d got=%b exp=000", i, {busy, s0v, s1v});
      end
    end
    r1v = 1; r1op = 3'b010; r1a = 32'hA5A5A5A5; r1b = 32'h5A5A5A5A;
    #1;
    checks++;
    if ({r1rdy, r0rdy} !== 2'b10) begin
      errs++; $display("FAIL rmid_ready got=%b exp=10", {r1rdy, r0rdy});
    end
    @(posedge clk);
    @(negedge clk);
    r1v = 0;
    @(negedge clk);
    checks++;
    if ({s1v, s0v, s1d, gid} !== {2'b10, 32'hFFFFFFFF, 1'b1}) begin
      errs++; $display("FAIL rmid_rsp got=%h", {s1v, s0v, s1d, gid});
    end
    s1r = 1;
    @(negedge clk);
    s1r = 0;
    checks++;
    if ({busy, s1v} !== 2'b00) begin
      errs++; $display("FAIL rmid_idle got=%b exp=00", {busy, s1v});
    end
  endtask

  initial begin
    test_reset();
    test_xor_p0();
    test_both();
    test_backpressure();
    test_latency3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
